// File: rtl/alu_issue_stage_if.sv
// Instruction handshake channel into alu_issue_stage.
// Upstream drives instr/instr_valid; the stage returns instr_ready.
interface alu_issue_stage_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage (E, W) execute front end for a 16-bit
// combinational ALU, with an 8x16 register file, cmp flags and RAW handling.
// Compile-time option ALU_ISSUE_FWD_EN: when defined, RAW hazards are
// resolved by bypassing wb_data into E; otherwise E stalls for one cycle.
module alu_issue_stage (
    input  logic                    clk,
    input  logic                    rst,
    alu_issue_stage_if.slave        instr_if,
    output logic [15:0]             alu_a_o,
    output logic [15:0]             alu_b_o,
    output logic [2:0]              alu_sel_o,
    input  logic [15:0]             alu_result_i,
    output logic                    wb_valid_o,
    output logic [2:0]              wb_rd_o,
    output logic [15:0]             wb_data_o,
    output logic                    flag_gt_o,
    output logic                    flag_lt_o,
    output logic                    flag_eq_o,
    input  logic [2:0]              dbg_addr_i,
    output logic [15:0]             dbg_data_o
);

    localparam int unsigned DW   = 16;
    localparam int unsigned RW   = 3;
    localparam int unsigned NREG = 8;
    localparam int unsigned IMMW = 6;
    localparam logic [2:0]  OP_CMP = 3'd7;

    typedef struct packed {
        logic [2:0]      op;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   ra;
        logic            imm;
        logic [IMMW-1:0] lo;    // rb in [5:3] when imm=0, imm6 when imm=1
    } instr_t;

    logic [DW-1:0] rf_q [NREG];

    logic          e_valid_q, e_valid_d;
    instr_t        e_instr_q, e_instr_d;
    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          flag_gt_q, flag_gt_d;
    logic          flag_lt_q, flag_lt_d;
    logic          flag_eq_q, flag_eq_d;

    logic [RW-1:0] e_ra, e_rb;
    logic [DW-1:0] opnd_a, opnd_b;
    logic          haz_a, haz_b;
    logic          stall;
    logic          accept;

    // Operand read, hazard detection, and ALU drive for the E stage
    always_comb begin
        e_ra   = e_instr_q.ra;
        e_rb   = e_instr_q.lo[5:3];
        haz_a  = e_valid_q && wb_valid_q && (wb_rd_q != '0) && (wb_rd_q == e_ra);
        haz_b  = e_valid_q && wb_valid_q && (wb_rd_q != '0) && !e_instr_q.imm
                 && (wb_rd_q == e_rb);
`ifdef ALU_ISSUE_FWD_EN
        opnd_a = haz_a ? wb_data_q : rf_q[e_ra];
        opnd_b = haz_b ? wb_data_q : rf_q[e_rb];
        stall  = 1'b0;
`else
        opnd_a = rf_q[e_ra];
        opnd_b = rf_q[e_rb];
        stall  = haz_a || haz_b;
`endif
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_sel_o = '0;
        if (e_valid_q) begin
            alu_a_o   = opnd_a;
            alu_b_o   = e_instr_q.imm ? DW'(e_instr_q.lo) : opnd_b;
            alu_sel_o = e_instr_q.op;
        end
        instr_if.instr_ready = !rst && (!e_valid_q || !stall);
        accept = instr_if.instr_valid && instr_if.instr_ready;
    end

    // Next state for the E/W pipeline and the cmp flags
    always_comb begin
        e_valid_d  = e_valid_q;
        e_instr_d  = e_instr_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        flag_gt_d  = flag_gt_q;
        flag_lt_d  = flag_lt_q;
        flag_eq_d  = flag_eq_q;
        if (!stall) begin
            e_valid_d = accept;
            if (accept) begin
                e_instr_d = instr_t'(instr_if.instr);
            end
            if (e_valid_q) begin
                if (e_instr_q.op == OP_CMP) begin
                    flag_gt_d = (alu_result_i == DW'(1));
                    flag_lt_d = (alu_result_i == DW'(2));
                    flag_eq_d = (alu_result_i == DW'(0));
                end else begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = e_instr_q.rd;
                    wb_data_d  = alu_result_i;
                end
            end
        end
    end

    // State registers; register file written at the end of the W cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q  <= 1'b0;
            e_instr_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flag_gt_q  <= 1'b0;
            flag_lt_q  <= 1'b0;
            flag_eq_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            e_valid_q  <= e_valid_d;
            e_instr_q  <= e_instr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            flag_gt_q  <= flag_gt_d;
            flag_lt_q  <= flag_lt_d;
            flag_eq_q  <= flag_eq_d;
            if (wb_valid_q && (wb_rd_q != '0)) begin
                rf_q[wb_rd_q] <= wb_data_q;
            end
        end
    end

    // Registered outputs and the debug read port (no write-through)
    always_comb begin
        wb_valid_o = wb_valid_q;
        wb_rd_o    = wb_rd_q;
        wb_data_o  = wb_data_q;
        flag_gt_o  = flag_gt_q;
        flag_lt_o  = flag_lt_q;
        flag_eq_o  = flag_eq_q;
        dbg_data_o = rf_q[dbg_addr_i];
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: table of ALU op vectors,
// hand sequences for timing/hazard/reset corners, and a writeback scoreboard
// fed by an in-order architectural model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
    logic [2:0]  alu_sel, wb_rd, dbg_addr;
    logic        wb_valid, flag_gt, flag_lt, flag_eq;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr_if     (bus),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_sel_o    (alu_sel),
        .alu_result_i (alu_result),
        .wb_valid_o   (wb_valid),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .flag_gt_o    (flag_gt),
        .flag_lt_o    (flag_lt),
        .flag_eq_o    (flag_eq),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_o   (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[3:0];
            3'd6:    return a >> b[3:0];
            default: return (a == b) ? 16'd0 : ((a > b) ? 16'd1 : 16'd2);
        endcase
    endfunction

    // External combinational ALU
    always_comb alu_result = alu_f(alu_a, alu_b, alu_sel);

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [5:0] imm6);
        return {op, rd, ra, 1'b1, imm6};
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, 1'b0, rb, 3'b000};
    endfunction

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
    } wb_t;

    typedef struct {
        logic [15:0] ins;
        logic [2:0]  reg_chk;
        logic [15:0] exp;
    } vec_t;

    wb_t         sb[$];
    int          wb_cyc[$];
    logic [15:0] m_rf [8];
    logic        m_gt, m_lt, m_eq;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wb_count = 0;
    int          ready_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_gt = 1'b0; m_lt = 1'b0; m_eq = 1'b0;
    endtask

    // In-order architectural model; queues the expected writeback
    task automatic model_apply(input logic [15:0] ins);
        logic [2:0]  op, rd, ra, rb;
        logic [15:0] a, b, r;
        wb_t         e;
        op = ins[15:13]; rd = ins[12:10]; ra = ins[9:7]; rb = ins[5:3];
        a  = m_rf[ra];
        b  = ins[6] ? {10'b0, ins[5:0]} : m_rf[rb];
        r  = alu_f(a, b, op);
        if (op == 3'd7) begin
            m_gt = (r == 16'd1); m_lt = (r == 16'd2); m_eq = (r == 16'd0);
        end else begin
            e.rd = rd; e.data = r;
            sb.push_back(e);
            if (rd != 3'd0) m_rf[rd] = r;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Writeback monitor: pops the scoreboard on each wb_valid cycle
    always begin
        wb_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (!bus.instr_ready) ready_low++;
            if (wb_valid) begin
                wb_count++;
                wb_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("wb_unexpected", 32'(wb_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_data", 32'(wb_data), 32'(e.data));
                end
            end
        end
    end

    // Present one instruction, optionally after random idle cycles; returns just after the accepting edge
    task automatic issue(input logic [15:0] ins, input int max_idle);
        int n;
        n = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
        repeat (n) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
        end
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.instr_ready) begin
                @(posedge clk);
                model_apply(ins);
                return;
            end
            @(negedge clk);
        end
        check("issue_timeout", 32'(bus.instr_ready), 32'(1));
        bus.instr_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (5) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
        end
        check("sb_empty", 32'(sb.size()), 32'(0));
    endtask

    task automatic check_rf(input logic [2:0] r, input logic [15:0] exp, input string name);
        dbg_addr = r;
        #1;
        check(name, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   r0, n;

        vecs[0] = '{enc_i(3'd0, 3'd1, 3'd0, 6'd5), 3'd1, 16'd5};
        vecs[1] = '{enc_i(3'd0, 3'd2, 3'd0, 6'd3), 3'd2, 16'd3};
        vecs[2] = '{enc_r(3'd1, 3'd3, 3'd1, 3'd2), 3'd3, 16'd2};
        vecs[3] = '{enc_r(3'd2, 3'd4, 3'd1, 3'd2), 3'd4, 16'd1};
        vecs[4] = '{enc_r(3'd3, 3'd5, 3'd1, 3'd2), 3'd5, 16'd7};
        vecs[5] = '{enc_r(3'd4, 3'd6, 3'd1, 3'd2), 3'd6, 16'd6};
        vecs[6] = '{enc_r(3'd5, 3'd7, 3'd1, 3'd2), 3'd7, 16'd40};
        vecs[7] = '{enc_r(3'd6, 3'd3, 3'd1, 3'd2), 3'd3, 16'd0};
        vecs[8] = '{enc_r(3'd7, 3'd1, 3'd1, 3'd2), 3'd1, 16'd5};

        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
        dbg_addr = 3'd0;
        model_reset();

        // Reset clears everything
        @(negedge clk);
        #1;
        check("ready_in_reset", 32'(bus.instr_ready), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.instr_ready), 32'(1));
        check("wb_valid_reset", 32'(wb_valid), 32'(0));
        check("flags_reset", 32'({flag_gt, flag_lt, flag_eq}), 32'(0));
        for (int i = 0; i < 8; i++) check_rf(3'(i), 16'h0, "rf_reset");

        // Table: immediate loads and full op sweep
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].ins, 0);
            drain();
            check_rf(vecs[i].reg_chk, vecs[i].exp, "vec_rf");
        end
        check("cmp_flag_gt", 32'(flag_gt), 32'(1));
        check("cmp_flag_lt", 32'(flag_lt), 32'(0));
        check("cmp_flag_eq", 32'(flag_eq), 32'(0));
        check_rf(3'd2, 16'd3, "cmp_r2_unchanged");

        // Back-to-back writeback timing and old-value debug read
        issue(enc_i(3'd0, 3'd1, 3'd0, 6'd21), 0);
        issue(enc_i(3'd0, 3'd2, 3'd0, 6'd22), 0);
        #1;
        check("b2b_wb1_valid", 32'(wb_valid), 32'(1));
        check("b2b_wb1_rd", 32'(wb_rd), 32'(1));
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_wb2_valid", 32'(wb_valid), 32'(1));
        check("b2b_wb2_rd", 32'(wb_rd), 32'(2));
        check_rf(3'd1, 16'd21, "b2b_r1_visible");
        check_rf(3'd2, 16'd3, "b2b_r2_old_value");
        @(posedge clk);
        #1;
        check("b2b_wb_done", 32'(wb_valid), 32'(0));
        check_rf(3'd2, 16'd22, "b2b_r2_new");
        drain();

        // RAW back-to-back dependency
        r0 = ready_low;
        n  = wb_cyc.size();
        issue(enc_i(3'd0, 3'd3, 3'd0, 6'd9), 0);
        issue(enc_r(3'd0, 3'd4, 3'd3, 3'd3), 0);
        drain();
        check_rf(3'd4, 16'd18, "raw_r4");
        check("raw_wb_count", 32'(wb_cyc.size() - n), 32'(2));
`ifdef ALU_ISSUE_FWD_EN
        check("raw_ready_low", 32'(ready_low - r0), 32'(0));
        check("raw_wb_gap", 32'(wb_cyc[n+1] - wb_cyc[n]), 32'(1));
`else
        check("raw_ready_low", 32'(ready_low - r0), 32'(1));
        check("raw_wb_gap", 32'(wb_cyc[n+1] - wb_cyc[n]), 32'(2));
`endif

        // R0 write discarded, wb still pulses
        n = wb_count;
        issue(enc_i(3'd0, 3'd0, 3'd0, 6'd7), 0);
        drain();
        check("r0_wb_pulse", 32'(wb_count - n), 32'(1));
        check_rf(3'd0, 16'h0, "r0_zero");

        // Random stream with random valid gaps
        for (int i = 0; i < 40; i++) issue(16'($urandom), 2);
        drain();
        for (int i = 0; i < 8; i++) check_rf(3'(i), m_rf[i], "rand_rf");
        check("rand_flags", 32'({flag_gt, flag_lt, flag_eq}), 32'({m_gt, m_lt, m_eq}));

        // Reset while E holds an instruction
        issue(enc_i(3'd0, 3'd5, 3'd0, 6'd1), 0);
        rst = 1'b1;
        n = wb_count;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_reset();
        repeat (4) @(negedge clk);
        check("midreset_no_wb", 32'(wb_count - n), 32'(0));
        check_rf(3'd5, 16'h0, "midreset_r5");
        check("midreset_flags", 32'({flag_gt, flag_lt, flag_eq}), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
